cascade_inta_sequencer: RTL and testbench
=========================================

CASCADE_INTA_SEQUENCER -- requirements
Module: cascade_inta_sequencer

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of flops synchronising inta_n; legal range 2..3.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 inta_n  input  1  CPU interrupt-acknowledge strobe, active-low, asynchronous to clk.
REQ-005 irq_valid  input  1  priority resolver holds a pending request.
REQ-006 irq_level  input  3  highest-priority pending IR number, valid when irq_valid=1.
REQ-007 slave_map  input  8  ICW3 master mask: bit n=1 means a slave is cascaded on IRn.
REQ-008 sngl  input  1  ICW1 SNGL: 1 = no cascade in system.
REQ-009 mode_8086  input  1  ICW4 uPM: 1 = two-pulse 8086 cycle; 0 = three-pulse 8080 cycle.
REQ-010 cas_out  output  3  cascade ID driven to slaves.
REQ-011 cas_oe  output  1  enables the CAS pad drivers.
REQ-012 isr_set  output  1  one-cycle pulse: set the ISR bit for ack_level.
REQ-013 ack_level  output  3  IR level latched for the current acknowledge.
REQ-014 master_vec_en  output  1  master places its own vector/opcode byte on the data bus.
REQ-015 pulse_idx  output  2  index of the current INTA pulse, 1..3; 0 when idle.
REQ-016 ack_done  output  1  one-cycle pulse at the end of the final INTA pulse.

Function
REQ-017 inta_n SHALL pass through SYNC_STAGES flops, with reset value 1.
- fall = a synchronised 1->0 transition.
- rise = a synchronised 0->1 transition.
REQ-018 States: IDLE, PULSE (inta low), GAP (inta high between pulses).
REQ-019 IDLE->PULSE on fall.
- pulse_idx becomes 1.
- ack_level latches irq_level if irq_valid=1; otherwise it latches 7 (spurious-request rule).
- isr_set pulses in the same cycle as the transition, only if irq_valid=1.
REQ-020 Cascade flag SHALL be latched on the first fall as (sngl=0 AND slave_map[level]=1) and held until the sequence ends.
REQ-021 When the cascade flag is set:
- cas_out=ack_level and cas_oe=1 from the cycle after the first fall.
- Both hold through the cycle of the final rise.
- At all other times cas_out=0 and cas_oe=0.
REQ-022 PULSE->GAP on rise when pulse_idx is below the final pulse; final pulse is 2 when mode_8086=1, else 3.
REQ-023 GAP->PULSE on fall, with pulse_idx incremented.
REQ-024 On rise of the final pulse:
- PULSE->IDLE.
- ack_done pulses for one cycle.
- pulse_idx returns to 0.
REQ-025 master_vec_en SHALL be 1 while in PULSE with pulse_idx>=2 and the cascade flag clear.
REQ-026 In 8080 mode, master_vec_en SHALL also be 1 during pulse 1 (CALL opcode), regardless of the cascade flag.
REQ-027 mode_8086, sngl and slave_map SHALL be sampled only on the first fall; changes mid-sequence have no effect.
REQ-028 A fall while in PULSE is impossible. A rise while in IDLE SHALL be ignored.
REQ-029 isr_set SHALL pulse at most once per sequence; ack_done SHALL pulse exactly once per completed sequence.

Reset
REQ-030 While rst=1, and immediately on its assertion (including mid-sequence):
- state=IDLE and all synchroniser flops=1.
- cas_out=0, cas_oe=0, isr_set=0, ack_level=0.
- master_vec_en=0, pulse_idx=0, ack_done=0.
REQ-031 After rst deasserts, the block SHALL wait for a fresh fall; an inta_n already low SHALL NOT start a sequence until it has been seen high.

Structure
REQ-032 The state encoding, the spurious level constant 7 and the pulse-count constants (2, 3) belong in the shared PIC package used by the control logic and the cascade comparator.
REQ-033 The inta_n synchroniser with edge detect SHALL be one sub-module, inta_edge_sync, reusable by the slave-side comparator.

Verification
REQ-034 8086 cascade
- Stimulus: sngl=0, slave_map=8'h04, irq_valid=1, irq_level=2, two INTA pulses.
- Response: cas_out=2 and cas_oe=1 across both pulses; master_vec_en never 1; isr_set once; ack_done once after pulse 2.
REQ-035 8086 non-cascade
- Stimulus: slave_map=0, irq_level=5.
- Response: cas_oe=0; master_vec_en=1 only during pulse 2; ack_level=5.
REQ-036 8080 mode
- Stimulus: mode_8086=0, slave_map=8'h80, level 7, three pulses.
- Response: pulse_idx 1,2,3; cas_oe=1 until the third rise; master_vec_en=1 during pulse 1 only; ack_done after pulse 3.
REQ-037 Spurious request
- Stimulus: irq_valid=0 at the first fall.
- Response: ack_level=7; isr_set never pulses; the sequence completes normally.
REQ-038 Reset mid-sequence
- Stimulus: rst asserted in GAP after pulse 1, with inta_n held low across deassertion.
- Response: all outputs 0 at once; no sequence starts until inta_n goes high and then low again.
REQ-039 SNGL override
- Stimulus: sngl=1, slave_map=8'hFF, level 3.
- Response: cas_oe stays 0; master_vec_en=1 in pulse 2.

Source files
------------

// File: rtl/cascade_inta_sequencer_pkg.sv
// Shared PIC definitions: sequencer state encoding, the spurious-request
// level and the INTA pulse counts for the two CPU modes.
package cascade_inta_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } seq_state_t;

  // Level reported when INTA arrives with nothing pending.
  localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;

  // Number of INTA pulses in one acknowledge cycle.
  localparam logic [1:0] PULSES_8086 = 2'd2;
  localparam logic [1:0] PULSES_8080 = 2'd3;

  // A slave owns this acknowledge when cascading is enabled and the
  // acknowledged IR line has a slave attached.
  function automatic logic cascade_hit(input logic       sngl,
                                       input logic [7:0] slave_map,
                                       input logic [2:0] level);
    return !sngl && slave_map[level];
  endfunction

endpackage

// File: rtl/cascade_inta_sequencer_if.sv
// Bundle between the CPU/priority-resolver side and the INTA sequencer.
// There is no valid/ready handshake here: irq_valid is a level qualifier
// for irq_level (only meaningful while irq_valid=1, no back-pressure), and
// isr_set / ack_done are single-cycle strobes that are never stalled.
// modport master: CPU / priority resolver side (drives the requests).
// modport slave : the sequencer itself.
interface cascade_inta_sequencer_if;
  import cascade_inta_sequencer_pkg::*;

  logic       inta_n;
  logic       irq_valid;
  logic [2:0] irq_level;
  logic [7:0] slave_map;
  logic       sngl;
  logic       mode_8086;

  logic [2:0] cas_out;
  logic       cas_oe;
  logic       isr_set;
  logic [2:0] ack_level;
  logic       master_vec_en;
  logic [1:0] pulse_idx;
  logic       ack_done;
  seq_state_t dbg_state;

  modport master (
    output inta_n, irq_valid, irq_level, slave_map, sngl, mode_8086,
    input  cas_out, cas_oe, isr_set, ack_level, master_vec_en,
           pulse_idx, ack_done, dbg_state
  );

  modport slave (
    input  inta_n, irq_valid, irq_level, slave_map, sngl, mode_8086,
    output cas_out, cas_oe, isr_set, ack_level, master_vec_en,
           pulse_idx, ack_done, dbg_state
  );
endinterface

// File: rtl/cascade_inta_sequencer_inta_edge_sync.sv
// Synchroniser for the asynchronous active-low INTA strobe, with fall/rise
// detection. Edges are only reported once a genuinely sampled high level
// has been seen after reset, so a strobe that is already low when reset
// releases cannot fake a falling edge.
module inta_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async_n,
  output logic o_fall,
  output logic o_rise
);

  generate
    if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_stages
      $error("inta_edge_sync: SYNC_STAGES must be 2 or 3");
    end
  endgenerate

  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] r_fill;
  logic                   r_prev;
  logic                   r_armed;
  logic                   w_level;

  assign w_level = r_sync[SYNC_STAGES-1];

  // Shift the strobe through the synchroniser and track which stages hold
  // real samples rather than reset fill; arm once a real high is seen.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync  <= '1;
      r_fill  <= '0;
      r_prev  <= 1'b1;
      r_armed <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_async_n};
      r_fill  <= {r_fill[SYNC_STAGES-2:0], 1'b1};
      r_prev  <= w_level;
      r_armed <= r_armed | (r_fill[SYNC_STAGES-1] & w_level);
    end
  end

  assign o_fall = r_armed &  r_prev & ~w_level;
  assign o_rise = r_armed & ~r_prev &  w_level;

endmodule

// File: rtl/cascade_inta_sequencer.sv
// Master-side INTA sequencer: walks the 8086 two-pulse or 8080 three-pulse
// acknowledge, latches the acknowledged level, drives the cascade ID to a
// slave when one owns the request, and decides when the master itself
// places its vector/opcode on the data bus.
module cascade_inta_sequencer
  import cascade_inta_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  cascade_inta_sequencer_if.slave  pic
);

  logic       w_fall;
  logic       w_rise;
  logic [2:0] w_level;
  logic       w_casc;

  seq_state_t r_state;
  logic [1:0] r_pulse_idx;
  logic [1:0] r_final;
  logic       r_casc;
  logic [2:0] r_ack_level;
  logic [2:0] r_cas_out;
  logic       r_cas_oe;
  logic       r_isr_set;
  logic       r_ack_done;
  logic       r_mve;

  inta_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_async_n (pic.inta_n),
    .o_fall    (w_fall),
    .o_rise    (w_rise)
  );

  assign w_level = pic.irq_valid ? pic.irq_level : SPURIOUS_LEVEL;
  assign w_casc  = cascade_hit(pic.sngl, pic.slave_map, w_level);

  // Acknowledge FSM; all configuration is captured on the first fall and
  // every output is registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_pulse_idx <= 2'd0;
      r_final     <= PULSES_8086;
      r_casc      <= 1'b0;
      r_ack_level <= 3'd0;
      r_cas_out   <= 3'd0;
      r_cas_oe    <= 1'b0;
      r_isr_set   <= 1'b0;
      r_ack_done  <= 1'b0;
      r_mve       <= 1'b0;
    end else begin
      r_isr_set  <= 1'b0;
      r_ack_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_fall) begin
            r_state     <= ST_PULSE;
            r_pulse_idx <= 2'd1;
            r_ack_level <= w_level;
            r_isr_set   <= pic.irq_valid;
            r_casc      <= w_casc;
            r_final     <= pic.mode_8086 ? PULSES_8086 : PULSES_8080;
            r_cas_oe    <= w_casc;
            r_cas_out   <= w_casc ? w_level : 3'd0;
            // 8080 pulse 1 carries the CALL opcode from the master.
            r_mve       <= ~pic.mode_8086;
          end
        end
        ST_PULSE: begin
          if (w_rise) begin
            r_mve <= 1'b0;
            if (r_pulse_idx < r_final) begin
              r_state <= ST_GAP;
            end else begin
              r_state     <= ST_IDLE;
              r_pulse_idx <= 2'd0;
              r_ack_done  <= 1'b1;
              r_casc      <= 1'b0;
              r_cas_oe    <= 1'b0;
              r_cas_out   <= 3'd0;
            end
          end
        end
        ST_GAP: begin
          if (w_fall) begin
            r_state     <= ST_PULSE;
            r_pulse_idx <= 2'(r_pulse_idx + 2'd1);
            // Vector pulses come from the master only when no slave owns it.
            r_mve       <= ~r_casc;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign pic.cas_out       = r_cas_out;
  assign pic.cas_oe        = r_cas_oe;
  assign pic.isr_set       = r_isr_set;
  assign pic.ack_level     = r_ack_level;
  assign pic.master_vec_en = r_mve;
  assign pic.pulse_idx     = r_pulse_idx;
  assign pic.ack_done      = r_ack_done;
  assign pic.dbg_state     = r_state;

endmodule

// File: tb/tb_cascade_inta_sequencer.sv
// Bench for cascade_inta_sequencer: drives complete INTA sequences, pushes
// the expected observation tokens for each sequence into a queue and pops
// them as the DUT produces strobes or mid-pulse/mid-gap snapshots.
module tb_cascade_inta_sequencer;
  import cascade_inta_sequencer_pkg::*;

  localparam logic [3:0] K_ISR   = 4'h1;
  localparam logic [3:0] K_PULSE = 4'h2;
  localparam logic [3:0] K_GAP   = 4'h3;
  localparam logic [3:0] K_DONE  = 4'h4;
  localparam logic [3:0] K_IDLE  = 4'h5;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  logic [15:0] exp_q[$];

  cascade_inta_sequencer_if pic ();

  cascade_inta_sequencer #(.SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .pic (pic)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] obs,
                          input logic [15:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // {kind, pulse_idx, cas_oe, cas_out, master_vec_en, ack_level, 2'b0}
  function automatic logic [15:0] tok(input logic [3:0] kind,
                                      input logic [1:0] idx,
                                      input logic oe, input logic [2:0] out,
                                      input logic mve, input logic [2:0] lvl);
    return {kind, idx, oe, out, mve, lvl, 2'b00};
  endfunction

  function automatic logic [15:0] snap(input logic [3:0] kind);
    return tok(kind, pic.pulse_idx, pic.cas_oe, pic.cas_out,
               pic.master_vec_en, pic.ack_level);
  endfunction

  task automatic sb_pop(input string tag, input logic [3:0] kind);
    if (exp_q.size() == 0)
      check_eq({tag, " unexpected"}, snap(kind), 16'hF000);
    else
      check_eq(tag, snap(kind), exp_q.pop_front());
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: strobes are popped as the DUT emits them.
  always @(negedge clk) begin
    if (!rst) begin
      if (pic.isr_set)  sb_pop("isr_set", K_ISR);
      if (pic.ack_done) sb_pop("ack_done", K_DONE);
    end
  end

  // Expected tokens for one complete sequence, from the acknowledge rules.
  task automatic push_expect(input bit m86, input bit sngl_v,
                             input logic [7:0] map, input bit valid,
                             input logic [2:0] lvl_in, input int upto);
    logic [2:0] lvl;
    bit casc;
    int npulse;
    bit mve;
    lvl    = valid ? lvl_in : 3'd7;
    casc   = !sngl_v && map[lvl];
    npulse = m86 ? 2 : 3;
    if (upto < npulse) npulse = upto;
    if (valid) exp_q.push_back(tok(K_ISR, 2'd1, casc, casc ? lvl : 3'd0, !m86, lvl));
    for (int p = 1; p <= npulse; p++) begin
      mve = (p >= 2 && !casc) || (!m86 && p == 1);
      exp_q.push_back(tok(K_PULSE, 2'(p), casc, casc ? lvl : 3'd0, mve, lvl));
      if (p < (m86 ? 2 : 3))
        exp_q.push_back(tok(K_GAP, 2'(p), casc, casc ? lvl : 3'd0, 1'b0, lvl));
    end
    if (npulse == (m86 ? 2 : 3)) begin
      exp_q.push_back(tok(K_DONE, 2'd0, 1'b0, 3'd0, 1'b0, lvl));
      exp_q.push_back(tok(K_IDLE, 2'd0, 1'b0, 3'd0, 1'b0, lvl));
    end
  endtask

  // Driver: one acknowledge, optionally scrambling the config mid-sequence.
  task automatic run_seq(input bit m86, input bit sngl_v, input logic [7:0] map,
                         input bit valid, input logic [2:0] lvl, input bit perturb);
    int npulse;
    int w;
    npulse = m86 ? 2 : 3;
    pic.mode_8086 = m86;
    pic.sngl      = sngl_v;
    pic.slave_map = map;
    pic.irq_valid = valid;
    pic.irq_level = lvl;
    push_expect(m86, sngl_v, map, valid, lvl, 3);
    cycles(2);
    for (int p = 1; p <= npulse; p++) begin
      w = $urandom_range(6, 10);
      pic.inta_n = 1'b0;
      cycles(5);
      sb_pop("pulse", K_PULSE);
      cycles(w - 5);
      pic.inta_n = 1'b1;
      if (perturb && p == 1) begin
        pic.mode_8086 = ~m86;
        pic.sngl      = 1'($urandom_range(0, 1));
        pic.slave_map = 8'($urandom_range(0, 255));
        pic.irq_valid = 1'($urandom_range(0, 1));
        pic.irq_level = 3'($urandom_range(0, 7));
      end
      if (p < npulse) begin
        cycles(5);
        sb_pop("gap", K_GAP);
        cycles(w - 5);
      end else begin
        cycles(8);
        sb_pop("idle", K_IDLE);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, " cas_out"}, 16'(pic.cas_out), 16'h0);
    check_eq({tag, " cas_oe"}, 16'(pic.cas_oe), 16'h0);
    check_eq({tag, " isr_set"}, 16'(pic.isr_set), 16'h0);
    check_eq({tag, " ack_level"}, 16'(pic.ack_level), 16'h0);
    check_eq({tag, " mve"}, 16'(pic.master_vec_en), 16'h0);
    check_eq({tag, " pulse_idx"}, 16'(pic.pulse_idx), 16'h0);
    check_eq({tag, " ack_done"}, 16'(pic.ack_done), 16'h0);
    check_eq({tag, " state"}, 16'(pic.dbg_state), 16'(ST_IDLE));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst           = 1'b1;
    pic.inta_n    = 1'b1;
    pic.irq_valid = 1'b0;
    pic.irq_level = 3'd0;
    pic.slave_map = 8'h00;
    pic.sngl      = 1'b0;
    pic.mode_8086 = 1'b1;
    cycles(3);
    check_all_zero("reset");
    rst = 1'b0;
    cycles(4);

    // 8086 cascade on IR2
    run_seq(1'b1, 1'b0, 8'h04, 1'b1, 3'd2, 1'b0);
    // 8086 non-cascade, level 5
    run_seq(1'b1, 1'b0, 8'h00, 1'b1, 3'd5, 1'b0);
    // 8080 mode, slave on IR7
    run_seq(1'b0, 1'b0, 8'h80, 1'b1, 3'd7, 1'b0);
    // Spurious request (level forced to 7, IR7 not cascaded)
    run_seq(1'b1, 1'b0, 8'h04, 1'b0, 3'd3, 1'b0);
    // Single-PIC override ignores the slave map
    run_seq(1'b1, 1'b1, 8'hFF, 1'b1, 3'd3, 1'b0);
    // 8080 non-cascade, config scrambled mid-sequence
    run_seq(1'b0, 1'b0, 8'h00, 1'b1, 3'd1, 1'b1);

    // Reset in the gap after pulse 1, strobe held low across release
    pic.mode_8086 = 1'b1; pic.sngl = 1'b0; pic.slave_map = 8'h04;
    pic.irq_valid = 1'b1; pic.irq_level = 3'd2;
    push_expect(1'b1, 1'b0, 8'h04, 1'b1, 3'd2, 1);
    cycles(2);
    pic.inta_n = 1'b0;
    cycles(5);
    sb_pop("rst pulse", K_PULSE);
    cycles(3);
    pic.inta_n = 1'b1;
    cycles(5);
    sb_pop("rst gap", K_GAP);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_all_zero("mid rst");
    pic.inta_n = 1'b0;
    cycles(3);
    rst = 1'b0;
    cycles(12);
    check_eq("held low idx", 16'(pic.pulse_idx), 16'h0);
    check_eq("held low state", 16'(pic.dbg_state), 16'(ST_IDLE));
    check_eq("held low queue", 16'(exp_q.size()), 16'h0);
    pic.inta_n = 1'b1;
    cycles(6);
    run_seq(1'b1, 1'b0, 8'h04, 1'b1, 3'd2, 1'b0);

    // Random sequences with mid-sequence config changes
    for (int i = 0; i < 8; i++) begin
      run_seq(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
              3'($urandom_range(0, 7)), 1'b1);
    end

    cycles(4);
    check_eq("queue drained", 16'(exp_q.size()), 16'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
